// File: rtl/decode_queue_pkg.sv
// Shared definitions for the RV32I decode queue.
// Holds the RV32I opcode, funct3 and funct7 constants, the inner
// instruction-type codes (NOP = 0), the TRUE/FALSE and ZERO_WORD constants,
// the LSB routing and goal encodings, and the record that the output
// register carries.
package decode_queue_pkg;

  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam int unsigned INST_TYPE_W = 6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // Load/store funct3
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] LSB_NONE  = 2'b00;
  localparam logic [1:0] LSB_LOAD  = 2'b10;
  localparam logic [1:0] LSB_STORE = 2'b11;

  localparam logic [2:0] GOAL_NONE = 3'b000;
  localparam logic [2:0] GOAL_BYTE = 3'b001;
  localparam logic [2:0] GOAL_HALF = 3'b010;
  localparam logic [2:0] GOAL_WORD = 3'b100;

  typedef enum logic [INST_TYPE_W-1:0] {
    T_NOP = 6'd0,
    T_LUI, T_AUIPC, T_JAL, T_JALR,
    T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
    T_LB, T_LH, T_LW, T_LBU, T_LHU,
    T_SB, T_SH, T_SW,
    T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI, T_SLLI, T_SRLI, T_SRAI,
    T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU, T_XOR, T_SRL, T_SRA, T_OR, T_AND
  } inst_type_e;

  typedef struct packed {
    logic [INST_TYPE_W-1:0] typ;
    logic [31:0]            imm;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [4:0]             shamt;
    logic [1:0]             to_lsb;
    logic [2:0]             goal;
    logic                   occupy;
    logic                   illegal;
  } dec_out_t;

  // Access size from funct3[1:0]; the unsigned variants share the size.
  function automatic logic [2:0] mem_goal(input logic [1:0] sz);
    case (sz)
      2'b00:   return GOAL_BYTE;
      2'b01:   return GOAL_HALF;
      2'b10:   return GOAL_WORD;
      default: return GOAL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_queue_decode_logic.sv
// decode_logic: pure combinational RV32I instruction -> dispatch fields.
// Ports:
//   inst_i       raw 32-bit instruction
//   type_o       inner type code (NOP when illegal)
//   imm_o        sign-extended immediate for the instruction format
//   rs1_o/rs2_o/rd_o/shamt_o  raw register and shift-amount fields
//   to_lsb_o     bit1 = goes to LSB, bit0 = store
//   lsb_goal_o   one-hot access size
//   occupy_rd_o  instruction renames rd
//   illegal_o    undecodable encoding
module decode_logic
  import decode_queue_pkg::*;
(
  input  logic [31:0]            inst_i,
  output logic [INST_TYPE_W-1:0] type_o,
  output logic [31:0]            imm_o,
  output logic [4:0]             rs1_o,
  output logic [4:0]             rs2_o,
  output logic [4:0]             rd_o,
  output logic [4:0]             shamt_o,
  output logic [1:0]             to_lsb_o,
  output logic [2:0]             lsb_goal_o,
  output logic                   occupy_rd_o,
  output logic                   illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_base, f7_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  inst_type_e  typ;
  logic        ill, wr_rd;
  logic [1:0]  lsb;
  logic [2:0]  goal;

  assign opcode  = inst_i[6:0];
  assign f3      = inst_i[14:12];
  assign f7      = inst_i[31:25];
  assign f7_base = (f7 == F7_BASE);
  assign f7_alt  = (f7 == F7_ALT);

  assign rs1_o   = inst_i[19:15];
  assign rs2_o   = inst_i[24:20];
  assign rd_o    = inst_i[11:7];
  assign shamt_o = inst_i[24:20];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};

  always_comb begin
    typ   = T_NOP;
    imm_o = ZERO_WORD;
    ill   = FALSE;
    wr_rd = FALSE;
    lsb   = LSB_NONE;
    goal  = GOAL_NONE;
    case (opcode)
      OP_LUI:   begin typ = T_LUI;   imm_o = imm_u; wr_rd = TRUE; end
      OP_AUIPC: begin typ = T_AUIPC; imm_o = imm_u; wr_rd = TRUE; end
      OP_JAL:   begin typ = T_JAL;   imm_o = imm_j; wr_rd = TRUE; end
      OP_JALR:  begin typ = T_JALR;  imm_o = imm_i; wr_rd = TRUE; end
      OP_BRANCH: begin
        imm_o = imm_b;
        case (f3)
          F3_BEQ:  typ = T_BEQ;
          F3_BNE:  typ = T_BNE;
          F3_BLT:  typ = T_BLT;
          F3_BGE:  typ = T_BGE;
          F3_BLTU: typ = T_BLTU;
          F3_BGEU: typ = T_BGEU;
          default: ill = TRUE;
        endcase
      end
      OP_LOAD: begin
        imm_o = imm_i;
        wr_rd = TRUE;
        lsb   = LSB_LOAD;
        goal  = mem_goal(f3[1:0]);
        case (f3)
          F3_B:    typ = T_LB;
          F3_H:    typ = T_LH;
          F3_W:    typ = T_LW;
          F3_BU:   typ = T_LBU;
          F3_HU:   typ = T_LHU;
          default: ill = TRUE;
        endcase
      end
      OP_STORE: begin
        imm_o = imm_s;
        lsb   = LSB_STORE;
        goal  = mem_goal(f3[1:0]);
        case (f3)
          F3_B:    typ = T_SB;
          F3_H:    typ = T_SH;
          F3_W:    typ = T_SW;
          default: ill = TRUE;
        endcase
      end
      OP_IMM: begin
        imm_o = imm_i;
        wr_rd = TRUE;
        case (f3)
          F3_ADD:  typ = T_ADDI;
          F3_SLT:  typ = T_SLTI;
          F3_SLTU: typ = T_SLTIU;
          F3_XOR:  typ = T_XORI;
          F3_OR:   typ = T_ORI;
          F3_AND:  typ = T_ANDI;
          F3_SLL:  if (f7_base) typ = T_SLLI; else ill = TRUE;
          F3_SR: begin
            if (f7_base)     typ = T_SRLI;
            else if (f7_alt) typ = T_SRAI;
            else             ill = TRUE;
          end
          default: ill = TRUE;
        endcase
      end
      OP_REG: begin
        wr_rd = TRUE;
        case (f3)
          F3_ADD:  if (f7_alt) typ = T_SUB; else typ = T_ADD;
          F3_SR:   if (f7_alt) typ = T_SRA; else typ = T_SRL;
          F3_SLL:  typ = T_SLL;
          F3_SLT:  typ = T_SLT;
          F3_SLTU: typ = T_SLTU;
          F3_XOR:  typ = T_XOR;
          F3_OR:   typ = T_OR;
          F3_AND:  typ = T_AND;
          default: ill = TRUE;
        endcase
        // The alternate funct7 only selects SUB/SRA; any other non-zero funct7 is undefined.
        if (!(f7_base || (f7_alt && (f3 == F3_ADD || f3 == F3_SR)))) ill = TRUE;
      end
      // Fences and system calls are legal but carry no work for dispatch.
      OP_FENCE, OP_SYSTEM: imm_o = imm_i;
      default: ill = TRUE;
    endcase
    // Illegal encodings travel as NOPs so the ROB can trap without side effects.
    if (ill) begin
      typ  = T_NOP;
      lsb  = LSB_NONE;
      goal = GOAL_NONE;
    end
  end

  assign type_o      = typ;
  assign to_lsb_o    = lsb;
  assign lsb_goal_o  = goal;
  assign illegal_o   = ill;
  assign occupy_rd_o = wr_rd && !ill && (inst_i[11:7] != 5'd0);

endmodule

// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I decode stage between fetch and dispatch.
// Fetched instructions enter a QUEUE_DEPTH-entry FIFO (fet_valid_in /
// fet_ready_out); the head is decoded by decode_logic and captured in an
// output register presented to dispatch (dis_valid_out / dis_ready_in).
// flush_in empties the queue and the output register; rst is synchronous,
// active-low. count_out reports FIFO occupancy (output register excluded).
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 8,
  parameter int unsigned INST_TYPE_WIDTH = 6,
  parameter int unsigned PC_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fet_valid_in,
  input  logic [31:0]                  fet_inst_in,
  input  logic [PC_WIDTH-1:0]          fet_pc_in,
  output logic                         fet_ready_out,
  input  logic                         flush_in,
  input  logic                         dis_ready_in,
  output logic                         dis_valid_out,
  output logic [INST_TYPE_WIDTH-1:0]   dis_inst_type_out,
  output logic [31:0]                  dis_imm_out,
  output logic [4:0]                   dis_rs1_out,
  output logic [4:0]                   dis_rs2_out,
  output logic [4:0]                   dis_rd_out,
  output logic [4:0]                   dis_shamt_out,
  output logic [PC_WIDTH-1:0]          dis_pc_out,
  output logic [1:0]                   dis_to_lsb_out,
  output logic [2:0]                   dis_lsb_goal_out,
  output logic                         dis_occupy_rd_out,
  output logic                         dis_illegal_out,
  output logic [$clog2(QUEUE_DEPTH):0] count_out
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]         inst_mem_q [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0] pc_mem_q   [QUEUE_DEPTH];
  logic [AW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                valid_q, valid_d;
  dec_out_t            out_q, out_d, dec;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                push, pop;

  logic [INST_TYPE_W-1:0] dec_typ;
  logic [31:0]            dec_imm;
  logic [4:0]             dec_rs1, dec_rs2, dec_rd, dec_shamt;
  logic [1:0]             dec_lsb;
  logic [2:0]             dec_goal;
  logic                   dec_occ, dec_ill;

  decode_logic u_decode (
    .inst_i      (inst_mem_q[head_q]),
    .type_o      (dec_typ),
    .imm_o       (dec_imm),
    .rs1_o       (dec_rs1),
    .rs2_o       (dec_rs2),
    .rd_o        (dec_rd),
    .shamt_o     (dec_shamt),
    .to_lsb_o    (dec_lsb),
    .lsb_goal_o  (dec_goal),
    .occupy_rd_o (dec_occ),
    .illegal_o   (dec_ill)
  );

  assign dec = '{typ: dec_typ, imm: dec_imm, rs1: dec_rs1, rs2: dec_rs2,
                 rd: dec_rd, shamt: dec_shamt, to_lsb: dec_lsb, goal: dec_goal,
                 occupy: dec_occ, illegal: dec_ill};

  // Ready depends only on registered occupancy: a full queue never passes through.
  assign fet_ready_out = (count_q < CW'(QUEUE_DEPTH));
  assign push = fet_valid_in && fet_ready_out;
  assign pop  = (count_q != '0) && (!valid_q || dis_ready_in);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    out_d   = out_q;
    pc_d    = pc_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop) begin
        head_d  = head_q + 1'b1;
        valid_d = 1'b1;
        out_d   = dec;
        pc_d    = pc_mem_q[head_q];
      end else if (dis_ready_in) begin
        valid_d = 1'b0;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      pc_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !flush_in) begin
      inst_mem_q[tail_q] <= fet_inst_in;
      pc_mem_q[tail_q]   <= fet_pc_in;
    end
  end

  assign dis_valid_out     = valid_q;
  assign dis_inst_type_out = INST_TYPE_WIDTH'(out_q.typ);
  assign dis_imm_out       = out_q.imm;
  assign dis_rs1_out       = out_q.rs1;
  assign dis_rs2_out       = out_q.rs2;
  assign dis_rd_out        = out_q.rd;
  assign dis_shamt_out     = out_q.shamt;
  assign dis_pc_out        = pc_q;
  assign dis_to_lsb_out    = out_q.to_lsb;
  assign dis_lsb_goal_out  = out_q.goal;
  assign dis_occupy_rd_out = out_q.occupy;
  assign dis_illegal_out   = out_q.illegal;
  assign count_out         = count_q;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fet_valid_in = 1'b0;
  logic [31:0] fet_inst_in = '0;
  logic [31:0] fet_pc_in = '0;
  logic        fet_ready_out;
  logic        flush_in = 1'b0;
  logic        dis_ready_in = 1'b0;
  logic        dis_valid_out;
  logic [5:0]  dis_inst_type_out;
  logic [31:0] dis_imm_out;
  logic [4:0]  dis_rs1_out, dis_rs2_out, dis_rd_out, dis_shamt_out;
  logic [31:0] dis_pc_out;
  logic [1:0]  dis_to_lsb_out;
  logic [2:0]  dis_lsb_goal_out;
  logic        dis_occupy_rd_out, dis_illegal_out;
  logic [3:0]  count_out;

  always #5 clk = ~clk;

  decode_queue #(.QUEUE_DEPTH(DEPTH), .INST_TYPE_WIDTH(6), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .fet_valid_in(fet_valid_in), .fet_inst_in(fet_inst_in), .fet_pc_in(fet_pc_in),
    .fet_ready_out(fet_ready_out), .flush_in(flush_in), .dis_ready_in(dis_ready_in),
    .dis_valid_out(dis_valid_out), .dis_inst_type_out(dis_inst_type_out),
    .dis_imm_out(dis_imm_out), .dis_rs1_out(dis_rs1_out), .dis_rs2_out(dis_rs2_out),
    .dis_rd_out(dis_rd_out), .dis_shamt_out(dis_shamt_out), .dis_pc_out(dis_pc_out),
    .dis_to_lsb_out(dis_to_lsb_out), .dis_lsb_goal_out(dis_lsb_goal_out),
    .dis_occupy_rd_out(dis_occupy_rd_out), .dis_illegal_out(dis_illegal_out),
    .count_out(count_out)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: legal encodings as a lookup table (-1 = don't care).
  typedef struct { int op; int f3; int f7; logic [5:0] typ; } rule_t;
  rule_t rules[$];

  function automatic void add_rule(input int op, input int f3, input int f7, input inst_type_e t);
    rule_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.typ = 6'(t);
    rules.push_back(r);
  endfunction

  typedef struct {
    logic [5:0]  typ;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd, shamt;
    logic [31:0] pc;
    logic [1:0]  lsb;
    logic [2:0]  goal;
    logic        occ, ill;
  } exp_t;

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int op, f3, f7, s, sgn, a, b, c, d;
    bit hit;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    s = int'(w); sgn = s >>> 31;
    hit = 0;
    e.typ = 6'(T_NOP);
    foreach (rules[k])
      if (!hit && rules[k].op == op && (rules[k].f3 < 0 || rules[k].f3 == f3) &&
          (rules[k].f7 < 0 || rules[k].f7 == f7)) begin
        hit = 1;
        e.typ = rules[k].typ;
      end
    e.ill = !hit;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.shamt = w[24:20]; e.pc = pc;
    case (op)
      'h37, 'h17: e.imm = w & 32'hFFFF_F000;
      'h6F: begin
        a = int'(w[19:12]); b = int'(w[20]); c = int'(w[30:21]);
        e.imm = 32'(sgn * 1048576 + a * 4096 + b * 2048 + c * 2);
      end
      'h63: begin
        a = int'(w[7]); b = int'(w[30:25]); c = int'(w[11:8]);
        e.imm = 32'(sgn * 4096 + a * 2048 + b * 32 + c * 2);
      end
      'h23: begin
        a = s >>> 25; d = int'(w[11:7]);
        e.imm = 32'(a * 32 + d);
      end
      'h67, 'h03, 'h13, 'h0F, 'h73: e.imm = 32'(s >>> 20);
      default: e.imm = 32'h0;
    endcase
    e.lsb = 2'b00; e.goal = 3'b000;
    if (hit && (op == 'h03 || op == 'h23)) begin
      e.lsb  = (op == 'h23) ? 2'b11 : 2'b10;
      e.goal = 3'(1 << (f3 % 4));
    end
    e.occ = hit && !(op inside {'h63, 'h23, 'h0F, 'h73}) && (w[11:7] != 5'd0);
    return e;
  endfunction

  initial begin
    add_rule('h37, -1, -1, T_LUI);  add_rule('h17, -1, -1, T_AUIPC);
    add_rule('h6F, -1, -1, T_JAL);  add_rule('h67, -1, -1, T_JALR);
    add_rule('h63, 0, -1, T_BEQ);   add_rule('h63, 1, -1, T_BNE);
    add_rule('h63, 4, -1, T_BLT);   add_rule('h63, 5, -1, T_BGE);
    add_rule('h63, 6, -1, T_BLTU);  add_rule('h63, 7, -1, T_BGEU);
    add_rule('h03, 0, -1, T_LB);    add_rule('h03, 1, -1, T_LH);
    add_rule('h03, 2, -1, T_LW);    add_rule('h03, 4, -1, T_LBU);
    add_rule('h03, 5, -1, T_LHU);
    add_rule('h23, 0, -1, T_SB);    add_rule('h23, 1, -1, T_SH);
    add_rule('h23, 2, -1, T_SW);
    add_rule('h13, 0, -1, T_ADDI);  add_rule('h13, 2, -1, T_SLTI);
    add_rule('h13, 3, -1, T_SLTIU); add_rule('h13, 4, -1, T_XORI);
    add_rule('h13, 6, -1, T_ORI);   add_rule('h13, 7, -1, T_ANDI);
    add_rule('h13, 1, 0, T_SLLI);   add_rule('h13, 5, 0, T_SRLI);
    add_rule('h13, 5, 32, T_SRAI);
    add_rule('h33, 0, 0, T_ADD);    add_rule('h33, 0, 32, T_SUB);
    add_rule('h33, 1, 0, T_SLL);    add_rule('h33, 2, 0, T_SLT);
    add_rule('h33, 3, 0, T_SLTU);   add_rule('h33, 4, 0, T_XOR);
    add_rule('h33, 5, 0, T_SRL);    add_rule('h33, 5, 32, T_SRA);
    add_rule('h33, 6, 0, T_OR);     add_rule('h33, 7, 0, T_AND);
    add_rule('h0F, -1, -1, T_NOP);  add_rule('h73, -1, -1, T_NOP);
  end

  // Scoreboard: fq = instructions accepted but not yet registered,
  // rexp/rv = instruction expected in the output register.
  exp_t fq[$];
  exp_t rexp;
  bit   rv = 0;

  always @(negedge clk) begin
    bit do_pop, do_push;
    if (!rst) begin
      fq.delete();
      rv = 0;
    end else begin
      chk("valid", 32'(dis_valid_out), 32'(rv));
      chk("count", 32'(count_out), 32'(fq.size()));
      chk("fet_ready", 32'(fet_ready_out), 32'(fq.size() < DEPTH));
      if (rv && dis_valid_out) begin
        chk("type", 32'(dis_inst_type_out), 32'(rexp.typ));
        chk("imm", dis_imm_out, rexp.imm);
        chk("rs1", 32'(dis_rs1_out), 32'(rexp.rs1));
        chk("rs2", 32'(dis_rs2_out), 32'(rexp.rs2));
        chk("rd", 32'(dis_rd_out), 32'(rexp.rd));
        chk("shamt", 32'(dis_shamt_out), 32'(rexp.shamt));
        chk("pc", dis_pc_out, rexp.pc);
        chk("to_lsb", 32'(dis_to_lsb_out), 32'(rexp.lsb));
        chk("goal", 32'(dis_lsb_goal_out), 32'(rexp.goal));
        chk("occupy", 32'(dis_occupy_rd_out), 32'(rexp.occ));
        chk("illegal", 32'(dis_illegal_out), 32'(rexp.ill));
      end
      if (flush_in) begin
        fq.delete();
        rv = 0;
      end else begin
        do_pop  = (fq.size() > 0) && (!rv || dis_ready_in);
        do_push = fet_valid_in && (fq.size() < DEPTH);
        if (do_pop) begin
          rexp = fq.pop_front();
          rv = 1;
        end else if (dis_ready_in) begin
          rv = 0;
        end
        if (do_push) fq.push_back(ref_decode(fet_inst_in, fet_pc_in));
      end
    end
  end

  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h33;
      9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73; 11: w[6:0] = 7'h33;
      default: ;
    endcase
    k = $urandom_range(0, 3);
    if (k == 0) w[31:25] = 7'h00;
    else if (k == 1) w[31:25] = 7'h20;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // Push one instruction into an empty queue and check the registered result.
  task automatic push_check(input string nm, input logic [31:0] w, input inst_type_e etyp,
                            input logic [31:0] eimm, input logic [1:0] elsb,
                            input logic [2:0] egoal, input logic eocc, input logic eill);
    dis_ready_in = 1; fet_valid_in = 1; fet_inst_in = w; fet_pc_in = pc_ctr;
    pc_ctr += 4;
    step();
    fet_valid_in = 0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(dis_valid_out), 32'd1);
    chk({nm, "_type"}, 32'(dis_inst_type_out), 32'(etyp));
    chk({nm, "_imm"}, dis_imm_out, eimm);
    chk({nm, "_lsb"}, 32'(dis_to_lsb_out), 32'(elsb));
    chk({nm, "_goal"}, 32'(dis_lsb_goal_out), 32'(egoal));
    chk({nm, "_occ"}, 32'(dis_occupy_rd_out), 32'(eocc));
    chk({nm, "_ill"}, 32'(dis_illegal_out), 32'(eill));
  endtask

  initial begin
    int acc;
    bit refused;

    rst = 0;
    step(); step();
    rst = 1;
    @(negedge clk);
    chk("rst_valid", 32'(dis_valid_out), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_ready", 32'(fet_ready_out), 32'd1);
    chk("rst_type", 32'(dis_inst_type_out), 32'(T_NOP));
    chk("rst_imm", dis_imm_out, 32'd0);
    chk("rst_misc", {dis_pc_out[26:0], dis_to_lsb_out, dis_lsb_goal_out},
        32'd0);
    chk("rst_flags", {30'd0, dis_occupy_rd_out, dis_illegal_out}, 32'd0);

    push_check("addi", 32'hFFF00293, T_ADDI, 32'hFFFF_FFFF, 2'b00, 3'b000, 1'b1, 1'b0);
    chk("addi_rd", 32'(dis_rd_out), 32'd5);
    push_check("sw", 32'hFE20AE23, T_SW, 32'hFFFF_FFFC, 2'b11, 3'b100, 1'b0, 1'b0);
    push_check("lbu", 32'h0000C183, T_LBU, 32'h0, 2'b10, 3'b001, 1'b1, 1'b0);
    push_check("badop", 32'h0000000B, T_NOP, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
    push_check("badbr", 32'h00002063, T_NOP, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
    push_check("badsub", 32'h023100B3, T_NOP, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
    push_check("add_x0", 32'h00208033, T_ADD, 32'h0, 2'b00, 3'b000, 1'b0, 1'b0);
    push_check("jal", 32'hFF9FF0EF, T_JAL, 32'hFFFF_FFF8, 2'b00, 3'b000, 1'b1, 1'b0);

    // Fill with the dispatcher stalled: 1 registered + DEPTH queued.
    step();
    dis_ready_in = 0;
    acc = 0; refused = 0;
    for (int i = 0; i < 12 && !refused; i++) begin
      fet_valid_in = 1; fet_inst_in = gen_inst(); fet_pc_in = pc_ctr; pc_ctr += 4;
      @(negedge clk);
      if (!fet_ready_out) refused = 1; else acc++;
      step();
    end
    fet_valid_in = 0;
    chk("fill_accepted", 32'(acc), 32'd9);
    chk("fill_count", 32'(count_out), 32'd8);
    chk("fill_ready", 32'(fet_ready_out), 32'd0);
    dis_ready_in = 1;
    repeat (12) step();
    chk("drain_count", 32'(count_out), 32'd0);

    // Flush with 1 registered + 4 queued, coincident with a push.
    dis_ready_in = 0;
    for (int i = 0; i < 5; i++) begin
      fet_valid_in = 1; fet_inst_in = gen_inst(); fet_pc_in = pc_ctr; pc_ctr += 4;
      step();
    end
    chk("preflush_count", 32'(count_out), 32'd4);
    chk("preflush_valid", 32'(dis_valid_out), 32'd1);
    fet_inst_in = 32'h00100093; fet_pc_in = 32'hDEAD_0000; flush_in = 1;
    step();
    flush_in = 0; fet_valid_in = 0;
    chk("flush_count", 32'(count_out), 32'd0);
    chk("flush_valid", 32'(dis_valid_out), 32'd0);
    dis_ready_in = 1;
    repeat (4) step();

    // Randomised traffic with occasional flush and one mid-stream reset.
    for (int k = 0; k < 3000; k++) begin
      fet_valid_in = ($urandom_range(0, 3) != 0);
      fet_inst_in  = gen_inst();
      fet_pc_in    = pc_ctr; pc_ctr += 4;
      dis_ready_in = (k < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush_in     = ($urandom_range(0, 63) == 0);
      rst          = (k != 1200);
      step();
      if (k == 1200) begin
        chk("midrst_count", 32'(count_out), 32'd0);
        chk("midrst_valid", 32'(dis_valid_out), 32'd0);
      end
    end
    rst = 1; fet_valid_in = 0; flush_in = 0; dis_ready_in = 1;
    repeat (12) step();
    chk("end_count", 32'(count_out), 32'd0);
    chk("end_valid", 32'(dis_valid_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
